uiudp_tx_packer: RTL and testbench
==================================

// Module: uiudp_tx_packer
// PURPOSE
// - Sits directly upstream of the UDP layer's user write channel (req/busy/valid/data/len).
// - Buffers a byte stream from an application source, such as the face/image pipeline, in an internal FIFO.
// - Cuts the stream into UDP payloads of PKT_LEN bytes and flushes a short final packet on a frame-last marker.
// - Drives the UDP write handshake so the source never has to handle packet timing.
// PARAMETERS
// - PKT_LEN  default 1024 : full-packet payload length in bytes; legal range 1..2**FIFO_AW.
// - FIFO_AW  default 11   : FIFO address width; depth = 2**FIFO_AW bytes.
// PORTS
// - I_clk            in   1  : single clock; the UDP write clock, same domain as the UDP write port.
// - I_reset_n        in   1  : asynchronous active-low reset.
// - I_s_valid        in   1  : source byte valid.
// - I_s_data         in   8  : source byte.
// - I_s_last         in   1  : marks the final byte of a frame; qualified by I_s_valid && O_s_ready.
// - O_s_ready        out  1  : source may write this cycle.
// - O_W_udp_req      out  1  : request to send one packet.
// - O_W_udp_len      out  16 : payload length of the requested packet; stable from req until DONE.
// - I_W_udp_busy     in   1  : UDP layer grant; high = accepting/sending the packet.
// - O_W_udp_valid    out  1  : payload byte valid.
// - O_W_udp_data     out  8  : payload byte.
// - O_fifo_cnt       out  FIFO_AW+1 : FIFO occupancy.
// BEHAVIOUR
// - Reset values:
//   - req, valid, data and len outputs = 0.
//   - O_s_ready = 0 while reset is asserted; 1 the cycle after release.
//   - FIFO empty, O_fifo_cnt = 0.
//   - flush_pending = 0, sequence counter = 0, state = IDLE.
// - FIFO:
//   - Single-clock, show-ahead; simultaneous push and pop allowed, count unchanged.
//   - O_s_ready = !full && !flush_pending.
//   - A write while !O_s_ready is ignored; the source must hold the byte.
// - flush_pending:
//   - Set on an accepted byte with I_s_last = 1.
//   - Cleared in DONE when the FIFO is empty.
//   - Bytes after a last marker therefore never share a packet with the previous frame.
// - FSM: IDLE -> REQ -> SEND -> DONE -> IDLE. All outputs are registered.
//   - IDLE:
//     - If cnt >= PKT_LEN: latch len = PKT_LEN.
//     - Else if flush_pending && cnt > 0: latch len = cnt.
//     - Otherwise stay in IDLE.
//     - When a len is latched, go to REQ.
//   - REQ:
//     - O_W_udp_req = 1, held indefinitely until I_W_udp_busy is sampled 1.
//     - Then req drops on the next edge and the FSM moves to SEND.
//   - SEND:
//     - O_W_udp_valid = 1 for exactly len consecutive cycles, no gaps.
//     - One FIFO pop per byte; data appears in write order.
//     - The first valid byte comes 1 cycle after busy is sampled high.
//     - After the last byte, valid drops and the FSM moves to DONE.
//   - DONE:
//     - Wait until I_W_udp_busy == 0, then return to IDLE.
//     - Clear flush_pending here if the FIFO is empty.
//     - The next req can assert no earlier than 1 cycle later.
// - Counters:
//   - The payload byte counter is 16-bit and compares against len - 1.
//   - len is never 0; a last marker on an empty FIFO cannot occur.
// - Boundaries:
//   - FIFO full: ready = 0 and no overwrite.
//   - A pop empties the FIFO while a push arrives in the same cycle: legal, count goes 1 -> 1.
//   - busy dropping during SEND is a protocol error; SEND still completes len bytes.
//   - Reset mid-operation: all outputs go to 0 immediately (asynchronous), FIFO contents are discarded, no partial packet resumes.
// CONFIGURATION
// - Macro UIUDP_TX_PACKER_SEQ_EN defined:
//   - Each packet is prefixed with a 2-byte big-endian sequence number.
//   - O_W_udp_len = payload + 2.
//   - The 2 header bytes are sent first in SEND, without FIFO pops.
//   - Sequence increments after each completed packet and wraps 0xFFFF -> 0x0000.
// - Macro UIUDP_TX_PACKER_SEQ_EN undefined:
//   - No header; len = payload; the sequence counter is absent.
// TESTING
// - PKT_LEN=8: push 0x00..0x0F, busy answers req after 2 cycles -> two packets, len=8, bytes 00..07 then 08..0F, each valid burst 8 cycles with no gaps.
// - Push 5 bytes 0xA0..0xA4 with last on 0xA4 -> one packet, len=5; O_s_ready=0 from the cycle after 0xA4 until DONE with the FIFO empty.
// - Hold busy low for 20 cycles after req -> req stays 1 for all 20, valid stays 0, and the first byte comes 1 cycle after busy=1.
// - FIFO_AW=4, PKT_LEN=16, busy stuck low, push 20 bytes -> ready=0 at cnt=16; after busy is released, 16 bytes out in order, then the remaining 4 are accepted.
// - Assert reset during byte 3 of SEND -> req/valid=0 in the same cycle; after release cnt=0, no req, ready=1.
// - SEQ_EN with PKT_LEN=4 and 12 bytes -> three packets, len=6, headers 00 00 / 00 01 / 00 02 followed by the payload.

Source files
------------

// File: rtl/uiudp_tx_packer.sv
`default_nettype none
// ============================================================================
// Module   : uiudp_tx_packer
// Purpose  : Buffers a source byte stream in a show-ahead FIFO and cuts it
//            into UDP payloads of PKT_LEN bytes. A frame-last marker flushes
//            a short final packet. The block drives the UDP write handshake
//            (req/busy/valid/data/len).
// Options  : UIUDP_TX_PACKER_SEQ_EN - prefix each packet with a 2-byte
//            big-endian sequence number (len = payload + 2).
// Revision : 1.0 - initial release
// ============================================================================
module uiudp_tx_packer #(
    parameter int PKT_LEN = 1024,
    parameter int FIFO_AW = 11
) (
    input  logic               I_clk,
    input  logic               I_reset_n,
    input  logic               I_s_valid,
    input  logic [7:0]         I_s_data,
    input  logic               I_s_last,
    output logic               O_s_ready,
    output logic               O_W_udp_req,
    output logic [15:0]        O_W_udp_len,
    input  logic               I_W_udp_busy,
    output logic               O_W_udp_valid,
    output logic [7:0]         O_W_udp_data,
    output logic [FIFO_AW:0]   O_fifo_cnt
);

    localparam int                c_depth_int = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]  c_depth     = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]  c_cnt_one   = 1;
    localparam logic [FIFO_AW:0]  c_pkt_cnt   = (FIFO_AW + 1)'(PKT_LEN);
    localparam logic [15:0]       c_pkt_len16 = 16'(PKT_LEN);
`ifdef UIUDP_TX_PACKER_SEQ_EN
    localparam logic [15:0]       c_hdr_len   = 16'd2;
`else
    localparam logic [15:0]       c_hdr_len   = 16'd0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 req_q, req_d;
    logic                 valid_q, valid_d;
    logic [7:0]           data_q, data_d;
    logic [15:0]          len_q, len_d;
    logic [15:0]          byte_cnt_q, byte_cnt_d;
    logic                 flush_q, flush_d;
    logic                 ready_q, ready_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     cnt_q, cnt_d;
`ifdef UIUDP_TX_PACKER_SEQ_EN
    logic [15:0]          seq_q, seq_d;
`endif

    logic                 w_push;
    logic                 w_pop;
    logic                 w_load;
    logic [7:0]           w_rd_data;
    logic [7:0]           fifo_mem [c_depth_int];

    // FIFO storage: no reset, contents are discarded by resetting the pointers
    always_ff @(posedge I_clk) begin
        if (w_push) begin
            fifo_mem[wr_ptr_q] <= I_s_data;
        end
    end

    assign w_rd_data = fifo_mem[rd_ptr_q];

    // Next-state logic for the packet FSM, FIFO pointers and handshake outputs
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        valid_d    = valid_q;
        data_d     = data_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        flush_d    = flush_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        w_pop      = 1'b0;
        w_load     = 1'b0;
        w_push     = I_s_valid && ready_q;
`ifdef UIUDP_TX_PACKER_SEQ_EN
        seq_d      = seq_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cnt_q >= c_pkt_cnt) begin
                    len_d   = c_pkt_len16 + c_hdr_len;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end else if (flush_q && (cnt_q != '0)) begin
                    len_d   = 16'(cnt_q) + c_hdr_len;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (I_W_udp_busy) begin
                    req_d      = 1'b0;
                    byte_cnt_d = 16'd0;
                    w_load     = 1'b1;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                // busy is deliberately ignored here: a packet always runs to len
                if (byte_cnt_q == (len_q - 16'd1)) begin
                    valid_d = 1'b0;
                    state_d = S_DONE;
`ifdef UIUDP_TX_PACKER_SEQ_EN
                    seq_d   = seq_q + 16'd1;
`endif
                end else begin
                    byte_cnt_d = byte_cnt_q + 16'd1;
                    w_load     = 1'b1;
                end
            end
            S_DONE: begin
                if (cnt_q == '0) begin
                    flush_d = 1'b0;
                end
                if (!I_W_udp_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Load the byte presented on the next cycle; header bytes bypass the FIFO
        if (w_load) begin
            valid_d = 1'b1;
`ifdef UIUDP_TX_PACKER_SEQ_EN
            if (byte_cnt_d == 16'd0) begin
                data_d = seq_q[15:8];
            end else if (byte_cnt_d == 16'd1) begin
                data_d = seq_q[7:0];
            end else begin
                data_d = w_rd_data;
                w_pop  = 1'b1;
            end
`else
            data_d = w_rd_data;
            w_pop  = 1'b1;
`endif
        end

        // Applied after the DONE clear so a new marker is never lost
        if (w_push && I_s_last) begin
            flush_d = 1'b1;
        end

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_push && !w_pop) begin
            cnt_d = cnt_q + c_cnt_one;
        end else if (!w_push && w_pop) begin
            cnt_d = cnt_q - c_cnt_one;
        end

        ready_d = (cnt_d != c_depth) && !flush_d;
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= 8'd0;
            len_q      <= 16'd0;
            byte_cnt_q <= 16'd0;
            flush_q    <= 1'b0;
            ready_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
`ifdef UIUDP_TX_PACKER_SEQ_EN
            seq_q      <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            flush_q    <= flush_d;
            ready_q    <= ready_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
`ifdef UIUDP_TX_PACKER_SEQ_EN
            seq_q      <= seq_d;
`endif
        end
    end

    assign O_s_ready     = ready_q;
    assign O_W_udp_req   = req_q;
    assign O_W_udp_len   = len_q;
    assign O_W_udp_valid = valid_q;
    assign O_W_udp_data  = data_q;
    assign O_fifo_cnt    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uiudp_tx_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uiudp_tx_packer
// Purpose  : Directed bench for uiudp_tx_packer (PKT_LEN=8, FIFO_AW=4) with a
//            byte/length scoreboard, an automatic busy responder and a
//            monitor that checks every output byte and burst length.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uiudp_tx_packer;

    localparam int PKT_LEN = 8;
    localparam int FIFO_AW = 4;
`ifdef UIUDP_TX_PACKER_SEQ_EN
    localparam int HDR = 2;
`else
    localparam int HDR = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic [7:0]       s_data;
    logic             s_last;
    logic             O_s_ready;
    logic             O_W_udp_req;
    logic [15:0]      O_W_udp_len;
    logic             I_W_udp_busy;
    logic             O_W_udp_valid;
    logic [7:0]       O_W_udp_data;
    logic [FIFO_AW:0] O_fifo_cnt;

    int               total = 0;
    int               bad   = 0;
    logic [7:0]       exp_q[$];
    int               exp_len[$];
    bit               auto_en  = 1'b1;
    int               busy_dly = 2;

    int               burst   = 0;
    int               cur_len = 0;
    logic             req_prev = 1'b0;
    logic [15:0]      seq_m = 16'd0;

    uiudp_tx_packer #(.PKT_LEN(PKT_LEN), .FIFO_AW(FIFO_AW)) dut (
        .I_clk         (clk),
        .I_reset_n     (rst_n),
        .I_s_valid     (s_valid),
        .I_s_data      (s_data),
        .I_s_last      (s_last),
        .O_s_ready     (O_s_ready),
        .O_W_udp_req   (O_W_udp_req),
        .O_W_udp_len   (O_W_udp_len),
        .I_W_udp_busy  (I_W_udp_busy),
        .O_W_udp_valid (O_W_udp_valid),
        .O_W_udp_data  (O_W_udp_data),
        .O_fifo_cnt    (O_fifo_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte at a negedge and hold it until accepted
    task automatic send_byte(input logic [7:0] d, input logic last);
        int g = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!O_s_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (!O_s_ready) begin
            check("send_timeout", 32'(O_s_ready), 32'd1);
        end else begin
            exp_q.push_back(d);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Wait until every expected packet has been delivered
    task automatic wait_idle(input string tag);
        int g = 0;
        while ((exp_q.size() != 0 || exp_len.size() != 0 || O_W_udp_valid ||
                I_W_udp_busy || burst != 0) && g < 600) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_drained"}, 32'(exp_q.size() + exp_len.size()), 32'd0);
        repeat (3) @(negedge clk);
        check({tag, "_cnt_zero"}, 32'(O_fifo_cnt), 32'd0);
    endtask

    // UDP-side responder: grants busy_dly cycles after req, releases after the burst
    initial begin
        int g;
        I_W_udp_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_en && O_W_udp_req && !I_W_udp_busy) begin
                for (int k = 1; k < busy_dly; k++) @(negedge clk);
                I_W_udp_busy = 1'b1;
                g = 0;
                while (!O_W_udp_valid && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                while (O_W_udp_valid && g < 2000) begin
                    @(negedge clk);
                    g++;
                end
                I_W_udp_busy = 1'b0;
            end
        end
    end

    // Output monitor: length on req, byte order, contiguous burst of len bytes
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst_n) begin
            burst    = 0;
            req_prev = 1'b0;
            seq_m    = 16'd0;
        end else begin
            if (O_W_udp_req && !req_prev) begin
                if (exp_len.size() == 0) begin
                    check("unexpected_req", 32'(exp_len.size()), 32'd1);
                end else begin
                    cur_len = exp_len.pop_front() + HDR;
                    check("req_len", 32'(O_W_udp_len), 32'(cur_len));
                end
            end
            if (O_W_udp_valid) begin
                if (HDR != 0 && burst < 2) begin
                    e = (burst == 0) ? seq_m[15:8] : seq_m[7:0];
                    check("hdr_byte", 32'(O_W_udp_data), 32'(e));
                end else if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("payload_byte", 32'(O_W_udp_data), 32'(e));
                end
                burst++;
            end else if (burst != 0) begin
                check("burst_len", 32'(burst), 32'(cur_len));
                check("len_stable", 32'(O_W_udp_len), 32'(cur_len));
                burst = 0;
                seq_m = seq_m + 16'd1;
            end
            req_prev = O_W_udp_req;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'd0;
        s_last  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(O_s_ready), 32'd0);
        check("rst_req", 32'(O_W_udp_req), 32'd0);
        check("rst_valid", 32'(O_W_udp_valid), 32'd0);
        check("rst_data", 32'(O_W_udp_data), 32'd0);
        check("rst_len", 32'(O_W_udp_len), 32'd0);
        check("rst_cnt", 32'(O_fifo_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(O_s_ready), 32'd1);

        // Two full packets from 16 bytes
        exp_len.push_back(8);
        exp_len.push_back(8);
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
        wait_idle("two_pkts");

        // Short frame flushed by last marker
        exp_len.push_back(5);
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 1'b0);
        send_byte(8'hA4, 1'b1);
        check("ready_low_after_last", 32'(O_s_ready), 32'd0);
        g = 0;
        while (!O_s_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("flush_ready_return", 32'(O_s_ready), 32'd1);
        check("flush_delivered_before_ready", 32'(exp_q.size()), 32'd0);
        check("flush_valid_idle_at_ready", 32'(O_W_udp_valid), 32'd0);
        wait_idle("flush");

        // busy held low for 20 cycles after req
        busy_dly = 21;
        exp_len.push_back(8);
        for (int i = 0; i < 8; i++) send_byte(8'h30 + 8'(i), 1'b0);
        g = 0;
        while (!O_W_udp_req && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("hold_req_seen", 32'(O_W_udp_req), 32'd1);
        for (int i = 0; i < 20; i++) begin
            check("hold_req_high", 32'(O_W_udp_req), 32'd1);
            check("hold_valid_low", 32'(O_W_udp_valid), 32'd0);
            @(negedge clk);
        end
        check("valid_low_at_grant", 32'(O_W_udp_valid), 32'd0);
        @(negedge clk);
        check("first_byte_one_after_grant", 32'(O_W_udp_valid), 32'd1);
        check("req_dropped_after_grant", 32'(O_W_udp_req), 32'd0);
        wait_idle("hold");
        busy_dly = 2;

        // FIFO full with busy stuck low
        auto_en = 1'b0;
        exp_len.push_back(8);
        exp_len.push_back(8);
        exp_len.push_back(4);
        for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i), 1'b0);
        check("full_cnt", 32'(O_fifo_cnt), 32'd16);
        check("full_ready", 32'(O_s_ready), 32'd0);
        s_valid = 1'b1;
        s_data  = 8'h99;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full_no_overwrite_cnt", 32'(O_fifo_cnt), 32'd16);
            check("full_ready_held", 32'(O_s_ready), 32'd0);
        end
        s_valid = 1'b0;
        auto_en = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(8'h50 + 8'(i), 1'b0);
        send_byte(8'h53, 1'b1);
        wait_idle("full");

        // Reset in the middle of SEND
        exp_len.push_back(8);
        for (int i = 0; i < 8; i++) send_byte(8'h60 + 8'(i), 1'b0);
        g = 0;
        while (!O_W_udp_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("mid_send_started", 32'(O_W_udp_valid), 32'd1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(O_W_udp_valid), 32'd0);
        check("async_rst_req", 32'(O_W_udp_req), 32'd0);
        check("async_rst_cnt", 32'(O_fifo_cnt), 32'd0);
        exp_q.delete();
        exp_len.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(O_s_ready), 32'd1);
        check("post_rst_cnt", 32'(O_fifo_cnt), 32'd0);
        g = 0;
        for (int i = 0; i < 10; i++) begin
            if (O_W_udp_req || O_W_udp_valid) g++;
            @(negedge clk);
        end
        check("post_rst_no_resume", 32'(g), 32'd0);

        // Normal operation after reset
        exp_len.push_back(3);
        send_byte(8'hC0, 1'b0);
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b1);
        wait_idle("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
